// File: rtl/extbus_pkg.sv
// Shared constants and types for the external-bus multi-port register file.
package extbus_pkg;

  localparam int EXTBUS_DW     = 64;
  localparam int EXTBUS_TW     = 8;
  localparam int EXTBUS_NPORTS = 4;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
  localparam int PORT_C = 2;
  localparam int PORT_X = 3;

  typedef struct packed {
    logic [EXTBUS_DW-1:0] data;
    logic [EXTBUS_TW-1:0] tag;
  } extbus_word_t;

endpackage

// File: rtl/extbus_wrarb.sv
// Fixed-priority write arbiter for one field of one word: lowest port index wins.
module extbus_wrarb
  import extbus_pkg::*;
#(
  parameter int NPORTS = EXTBUS_NPORTS
) (
  input  logic [NPORTS-1:0] req_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [NPORTS-1:0] lose_o
);

  logic taken;

  always_comb begin
    gnt_o  = '0;
    lose_o = '0;
    taken  = 1'b0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (req_i[p]) begin
        if (taken) begin
          lose_o[p] = 1'b1;
        end else begin
          gnt_o[p] = 1'b1;
          taken    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/extbus_mport.sv
// Multi-port register file for the external bus: per-port data/tag enables,
// registered reads, fixed-priority write arbitration and collision reporting.
module extbus_mport
  import extbus_pkg::*;
#(
  parameter  int NPORTS = EXTBUS_NPORTS,
  parameter  int DEPTH  = 4,
  parameter  int DW     = EXTBUS_DW,
  parameter  int TW     = EXTBUS_TW,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NPORTS-1:0]    en,
  input  logic [NPORTS-1:0]    ten,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  input  logic [NPORTS*TW-1:0] wtag,
  output logic [NPORTS*DW-1:0] rdata,
  output logic [NPORTS*TW-1:0] rtag,
  output logic [NPORTS-1:0]    collide
);

  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [TW-1:0] tag_q  [DEPTH];
  logic [TW-1:0] tag_d  [DEPTH];

  logic [NPORTS*DW-1:0] rdata_q, rdata_d;
  logic [NPORTS*TW-1:0] rtag_q, rtag_d;
  logic [NPORTS-1:0]    collide_q, collide_d;

  logic [DEPTH-1:0][NPORTS-1:0] dreq, treq, dgnt, tgnt, dlose, tlose;

  always_comb begin
    dreq = '0;
    treq = '0;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (addr[p*AW +: AW] == AW'(w)) begin
          dreq[w][p] = en[p] & we[p];
          treq[w][p] = ten[p] & we[p];
        end
      end
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    extbus_wrarb #(.NPORTS(NPORTS)) u_arb_data (
      .req_i  (dreq[w]),
      .gnt_o  (dgnt[w]),
      .lose_o (dlose[w])
    );
    extbus_wrarb #(.NPORTS(NPORTS)) u_arb_tag (
      .req_i  (treq[w]),
      .gnt_o  (tgnt[w]),
      .lose_o (tlose[w])
    );
  end

  always_comb begin
    collide_d = '0;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      data_d[w] = data_q[w];
      tag_d[w]  = tag_q[w];
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (dgnt[w][p]) data_d[w] = wdata[p*DW +: DW];
        if (tgnt[w][p]) tag_d[w]  = wtag[p*TW +: TW];
      end
      collide_d = collide_d | dlose[w] | tlose[w];
    end
  end

  // data_d already holds the winning write, so bypass is just a choice of source
  always_comb begin
    rdata_d = '0;
    rtag_d  = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (en[p] && !we[p]) begin
        rdata_d[p*DW +: DW] = (BYPASS != 0) ? data_d[addr[p*AW +: AW]]
                                            : data_q[addr[p*AW +: AW]];
      end
      if (ten[p] && !we[p]) begin
        rtag_d[p*TW +: TW] = (BYPASS != 0) ? tag_d[addr[p*AW +: AW]]
                                           : tag_q[addr[p*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        data_q[w] <= '0;
        tag_q[w]  <= '0;
      end
      rdata_q   <= '0;
      rtag_q    <= '0;
      collide_q <= '0;
    end else begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        data_q[w] <= data_d[w];
        tag_q[w]  <= tag_d[w];
      end
      rdata_q   <= rdata_d;
      rtag_q    <= rtag_d;
      collide_q <= collide_d;
    end
  end

  assign rdata   = rdata_q;
  assign rtag    = rtag_q;
  assign collide = collide_q;

endmodule

// File: tb/tb_extbus_mport.sv
// Randomised and directed bench for extbus_mport; drives a BYPASS=1 and a
// BYPASS=0 instance with identical stimulus and checks both against one model.
module tb_extbus_mport;
  import extbus_pkg::*;

  localparam int NP = 4;
  localparam int DEPTH = 4;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NP-1:0]    en, ten, we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*TW-1:0] wtag;

  logic [NP*DW-1:0] rdata_b, rdata_n;
  logic [NP*TW-1:0] rtag_b, rtag_n;
  logic [NP-1:0]    collide_b, collide_n;

  logic [NP*DW-1:0] exp_rd_b = '0, exp_rd_n = '0;
  logic [NP*TW-1:0] exp_rt_b = '0, exp_rt_n = '0;
  logic [NP-1:0]    exp_col = '0;

  extbus_word_t mem_m [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  extbus_mport #(.NPORTS(NP), .DEPTH(DEPTH), .DW(DW), .TW(TW), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n), .en(en), .ten(ten), .we(we), .addr(addr),
    .wdata(wdata), .wtag(wtag), .rdata(rdata_b), .rtag(rtag_b), .collide(collide_b)
  );

  extbus_mport #(.NPORTS(NP), .DEPTH(DEPTH), .DW(DW), .TW(TW), .BYPASS(0)) u_nob (
    .clk(clk), .reset_n(reset_n), .en(en), .ten(ten), .we(we), .addr(addr),
    .wdata(wdata), .wtag(wtag), .rdata(rdata_n), .rtag(rtag_n), .collide(collide_n)
  );

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata_b"}, rdata_b, '0);
    check({tag, "_rdata_n"}, rdata_n, '0);
    check({tag, "_rtag_b"}, 256'(rtag_b), '0);
    check({tag, "_rtag_n"}, 256'(rtag_n), '0);
    check({tag, "_col_b"}, 256'(collide_b), '0);
    check({tag, "_col_n"}, 256'(collide_n), '0);
  endtask

  // Compare process: outputs are meaningful 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    check("rdata_byp", rdata_b, exp_rd_b);
    check("rdata_nob", rdata_n, exp_rd_n);
    check("rtag_byp", 256'(rtag_b), 256'(exp_rt_b));
    check("rtag_nob", 256'(rtag_n), 256'(exp_rt_n));
    check("collide_byp", 256'(collide_b), 256'(exp_col));
    check("collide_nob", 256'(collide_n), 256'(exp_col));
  end

  task automatic model_reset();
    for (int w = 0; w < DEPTH; w++) mem_m[w] = '0;
    exp_rd_b = '0; exp_rd_n = '0;
    exp_rt_b = '0; exp_rt_n = '0;
    exp_col  = '0;
  endtask

  // Ports applied from highest to lowest index, so the lowest writer lands last and wins.
  task automatic model_eval();
    extbus_word_t nw [DEPTH];
    logic [NP-1:0] col;
    int a, b;
    for (int w = 0; w < DEPTH; w++) nw[w] = mem_m[w];
    for (int p = NP - 1; p >= 0; p--) begin
      a = int'(addr[p*AW +: AW]);
      if (we[p] && en[p])  nw[a].data = wdata[p*DW +: DW];
      if (we[p] && ten[p]) nw[a].tag  = wtag[p*TW +: TW];
    end
    col = '0;
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < p; q++) begin
        if (addr[p*AW +: AW] == addr[q*AW +: AW] && we[p] && we[q]) begin
          if (en[p] && en[q])   col[p] = 1'b1;
          if (ten[p] && ten[q]) col[p] = 1'b1;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      b = int'(addr[p*AW +: AW]);
      exp_rd_b[p*DW +: DW] = (en[p] && !we[p])  ? nw[b].data    : '0;
      exp_rd_n[p*DW +: DW] = (en[p] && !we[p])  ? mem_m[b].data : '0;
      exp_rt_b[p*TW +: TW] = (ten[p] && !we[p]) ? nw[b].tag     : '0;
      exp_rt_n[p*TW +: TW] = (ten[p] && !we[p]) ? mem_m[b].tag  : '0;
    end
    exp_col = col;
    for (int w = 0; w < DEPTH; w++) mem_m[w] = nw[w];
  endtask

  task automatic clr_in();
    en = '0; ten = '0; we = '0; addr = '0; wdata = '0; wtag = '0;
  endtask

  task automatic set_port(input int p, input logic e, input logic t, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] tg);
    en[p] = e; ten[p] = t; we[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    wtag[p*TW +: TW] = tg;
  endtask

  task automatic rand_in();
    for (int p = 0; p < NP; p++) begin
      set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, TW'($urandom_range(0, 255)));
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_all_words();
    for (int k = 0; k < DEPTH; k++) begin
      clr_in();
      for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 1'b0, AW'(k), '0, '0);
      cycle();
    end
  endtask

  initial begin
    clr_in();
    model_reset();
    #1 reset_n = 1'b0;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 1'b1, AW'(p), {$urandom, $urandom}, 8'hC3);
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset_hold");
    @(negedge clk);
    clr_in();
    reset_n = 1'b1;
    read_all_words();
    check("post_reset_read_rdata", rdata_b, '0);

    clr_in();
    set_port(PORT_A, 1'b1, 1'b1, 1'b1, 2'd2, 64'h0123_4567_89AB_CDEF, 8'h5A);
    cycle();
    clr_in();
    set_port(PORT_X, 1'b1, 1'b1, 1'b0, 2'd2, '0, '0);
    cycle();
    check("basic_rdata", rdata_b, {64'h0123_4567_89AB_CDEF, 192'h0});
    check("basic_rtag", 256'(rtag_b), 256'({8'h5A, 24'h0}));

    clr_in();
    set_port(PORT_B, 1'b1, 1'b1, 1'b1, 2'd1, 64'h1, 8'h0);
    set_port(PORT_C, 1'b1, 1'b1, 1'b1, 2'd1, 64'h2, 8'h0);
    cycle();
    check("collide_set", 256'(collide_b), 256'(4'b0100));
    clr_in();
    set_port(PORT_A, 1'b1, 1'b0, 1'b0, 2'd1, '0, '0);
    cycle();
    check("collide_clear", 256'(collide_b), '0);
    check("collide_winner", 256'(rdata_b[PORT_A*DW +: DW]), 256'(64'h1));

    clr_in();
    set_port(PORT_B, 1'b1, 1'b0, 1'b1, 2'd3, 64'hFF, 8'hEE);
    cycle();
    clr_in();
    set_port(PORT_A, 1'b0, 1'b1, 1'b0, 2'd3, '0, '0);
    cycle();
    check("split_tagonly_rdata", rdata_b, '0);
    check("split_tagonly_rtag", 256'(rtag_b), '0);
    set_port(PORT_A, 1'b1, 1'b1, 1'b0, 2'd3, '0, '0);
    cycle();
    check("split_data", 256'(rdata_b[PORT_A*DW +: DW]), 256'(64'hFF));

    clr_in();
    set_port(PORT_A, 1'b1, 1'b1, 1'b1, 2'd0, 64'hAA, 8'h11);
    set_port(PORT_X, 1'b1, 1'b1, 1'b0, 2'd0, '0, '0);
    cycle();
    check("bypass_on", 256'(rdata_b[PORT_X*DW +: DW]), 256'(64'hAA));
    check("bypass_on_tag", 256'(rtag_b[PORT_X*TW +: TW]), 256'(8'h11));
    check("bypass_off", 256'(rdata_n[PORT_X*DW +: DW]), '0);

    for (int i = 0; i < 2000; i++) begin
      rand_in();
      cycle();
    end

    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 1'b1, AW'(p), {$urandom, $urandom}, 8'h77);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clr_in();
    reset_n = 1'b1;
    read_all_words();

    for (int i = 0; i < 300; i++) begin
      rand_in();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
